// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver feeding the calculator's rx_data/rx_data_rdy inputs.
// rxd is double-flopped before use. Only the synchronized line (w_rxs) drives the FSM.
// The start bit is checked at mid-bit. Data and stop bits are then sampled one bit period apart.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BIT_CNT_W    = 8
) (
    input  logic       clk12m,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [BIT_CNT_W-1:0] HALF_M1 = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_M1 = BIT_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH,
        S_WAIT_IDLE
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_stop_ok;
    logic [7:0]           r_data;
    logic                 r_rdy;
    logic                 r_err;
    logic                 r_busy;
    logic                 w_rxs;

    assign w_rxs        = r_sync2;
    assign rx_data      = r_data;
    assign rx_data_rdy  = r_rdy;
    assign rx_frame_err = r_err;
    assign rx_busy      = r_busy;

    // Two-flop synchronizer. It resets to the idle (high) line level.
    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM. It uses the baud counter, the bit index and the shift register, and registers all outputs.
    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_stop_ok <= 1'b0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= S_DATA;
                        end else begin
                            // The start bit did not survive to mid-bit, so it was a glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rxs;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_stop_ok <= w_rxs;
                        r_state   <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    if (r_stop_ok) begin
                        r_data  <= r_shift;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // A low stop bit may be a break, so wait for the line to return high.
                        r_err   <= 1'b1;
                        r_state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames at CLKS_PER_BIT=4 with hand-computed pulse cycles and data.
// Cycle t0 is the posedge that first captures the start bit.
// A good byte gives rdy at t0+41, and busy is seen high from t0+2 through t0+40.
module tb_uart_rx_byte;

    localparam int unsigned C = 4;

    logic       clk12m = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx_byte #(
        .CLKS_PER_BIT(C),
        .BIT_CNT_W   (4)
    ) dut (
        .clk12m      (clk12m),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk12m = ~clk12m;

    // Posedge counter: at a negedge, cyc is the index of the most recent posedge.
    int unsigned cyc = 0;
    always @(posedge clk12m) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int unsigned rdy_cyc_q[$];
    logic [7:0]  rdy_dat_q[$];
    int unsigned err_cyc_q[$];
    int unsigned busy_cnt;
    int unsigned busy_first;
    int unsigned busy_last;
    int unsigned both_cnt = 0;

    always @(negedge clk12m) begin
        if (!rst) begin
            if (rx_data_rdy) begin
                rdy_cyc_q.push_back(cyc);
                rdy_dat_q.push_back(rx_data);
            end
            if (rx_frame_err) err_cyc_q.push_back(cyc);
            if (rx_data_rdy && rx_frame_err) both_cnt++;
            if (rx_busy) begin
                busy_cnt++;
                if (busy_first == 32'hFFFF_FFFF) busy_first = cyc;
                busy_last = cyc;
            end
        end
    end

    task automatic clear_mon();
        rdy_cyc_q.delete();
        rdy_dat_q.delete();
        err_cyc_q.delete();
        busy_cnt   = 0;
        busy_first = 32'hFFFF_FFFF;
        busy_last  = 32'hFFFF_FFFF;
    endtask

    function automatic logic [31:0] rdy_cyc_at(input int i);
        if (i < rdy_cyc_q.size()) return rdy_cyc_q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rdy_dat_at(input int i);
        if (i < rdy_dat_q.size()) return 32'(rdy_dat_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] err_cyc_at(input int i);
        if (i < err_cyc_q.size()) return err_cyc_q[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Each bit is driven at a negedge and held for C posedges.
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (C) @(negedge clk12m);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk12m);
    endtask

    int unsigned t0;
    int unsigned tx;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk12m);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_rdy",  32'(rx_data_rdy), 32'h0);
        check("rst_err",  32'(rx_frame_err), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        idle(5);

        // Single frame, '0'
        clear_mon();
        send_frame(8'h30, 1'b1, t0);
        idle(10);
        check("t1_rdy_count", 32'(rdy_cyc_q.size()), 32'd1);
        check("t1_rdy_cyc",   rdy_cyc_at(0), t0 + 41);
        check("t1_rdy_data",  rdy_dat_at(0), 32'h30);
        check("t1_err_count", 32'(err_cyc_q.size()), 32'd0);
        check("t1_busy_first", busy_first, t0 + 2);
        check("t1_busy_last",  busy_last, t0 + 40);
        check("t1_busy_cnt",   busy_cnt, 32'd39);
        check("t1_hold",       32'(rx_data), 32'h30);

        // Back-to-back '5','2','-'
        clear_mon();
        send_frame(8'h35, 1'b1, t0);
        send_frame(8'h32, 1'b1, tx);
        send_frame(8'h2D, 1'b1, tx);
        idle(10);
        check("t2_rdy_count", 32'(rdy_cyc_q.size()), 32'd3);
        check("t2_cyc0", rdy_cyc_at(0), t0 + 41);
        check("t2_cyc1", rdy_cyc_at(1), t0 + 81);
        check("t2_cyc2", rdy_cyc_at(2), t0 + 121);
        check("t2_dat0", rdy_dat_at(0), 32'h35);
        check("t2_dat1", rdy_dat_at(1), 32'h32);
        check("t2_dat2", rdy_dat_at(2), 32'h2D);
        check("t2_err_count", 32'(err_cyc_q.size()), 32'd0);

        // One-cycle glitch on the line
        clear_mon();
        rxd = 1'b0;
        t0  = cyc + 1;
        @(negedge clk12m);
        idle(12);
        check("t3_rdy_count", 32'(rdy_cyc_q.size()), 32'd0);
        check("t3_err_count", 32'(err_cyc_q.size()), 32'd0);
        check("t3_busy_cnt",  busy_cnt, 32'd2);
        check("t3_busy_first", busy_first, t0 + 2);
        check("t3_data_hold", 32'(rx_data), 32'h2D);

        // Good 0x34, then 0x41 with a low stop bit and an extended low line
        clear_mon();
        send_frame(8'h34, 1'b1, t0);
        idle(6);
        check("t4a_rdy_count", 32'(rdy_cyc_q.size()), 32'd1);
        check("t4a_rdy_data",  rdy_dat_at(0), 32'h34);
        clear_mon();
        send_frame(8'h41, 1'b0, t0);
        repeat (12) @(negedge clk12m);
        idle(8);
        check("t4b_err_count", 32'(err_cyc_q.size()), 32'd1);
        check("t4b_err_cyc",   err_cyc_at(0), t0 + 41);
        check("t4b_rdy_count", 32'(rdy_cyc_q.size()), 32'd0);
        check("t4b_data_hold", 32'(rx_data), 32'h34);
        check("t4b_busy_last", busy_last, t0 + 53);
        clear_mon();
        send_frame(8'h2B, 1'b1, t0);
        idle(10);
        check("t4c_rdy_count", 32'(rdy_cyc_q.size()), 32'd1);
        check("t4c_rdy_cyc",   rdy_cyc_at(0), t0 + 41);
        check("t4c_rdy_data",  rdy_dat_at(0), 32'h2B);
        check("t4c_err_count", 32'(err_cyc_q.size()), 32'd0);

        // Async reset during data bit 3 of 0xA5
        clear_mon();
        t0 = cyc + 1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b0;
        @(posedge clk12m);
        @(posedge clk12m);
        #2;
        check("t5_busy_pre", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_rdy",  32'(rx_data_rdy), 32'h0);
        check("t5_rst_err",  32'(rx_frame_err), 32'h0);
        check("t5_rst_busy", 32'(rx_busy), 32'h0);
        @(negedge clk12m);
        rxd = 1'b1;
        repeat (3) @(negedge clk12m);
        rst = 1'b0;
        clear_mon();
        idle(60);
        check("t5_abort_rdy", 32'(rdy_cyc_q.size()), 32'd0);
        check("t5_abort_err", 32'(err_cyc_q.size()), 32'd0);
        clear_mon();
        send_frame(8'h5A, 1'b1, t0);
        idle(10);
        check("t5_rdy_count", 32'(rdy_cyc_q.size()), 32'd1);
        check("t5_rdy_cyc",   rdy_cyc_at(0), t0 + 41);
        check("t5_rdy_data",  rdy_dat_at(0), 32'h5A);

        // 0x00 then 0xFF back to back
        clear_mon();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, tx);
        idle(10);
        check("t6_rdy_count", 32'(rdy_cyc_q.size()), 32'd2);
        check("t6_cyc0", rdy_cyc_at(0), t0 + 41);
        check("t6_cyc1", rdy_cyc_at(1), t0 + 81);
        check("t6_dat0", rdy_dat_at(0), 32'h00);
        check("t6_dat1", rdy_dat_at(1), 32'hFF);
        check("t6_err_count", 32'(err_cyc_q.size()), 32'd0);

        check("rdy_err_overlap", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial receiver that deserializes an asynchronous 8N1 line into bytes for the calculator core, which consumes a byte plus a one-cycle ready strobe. It sits directly upstream of the calculator's rx_data/rx_data_rdy inputs. It replaces the bench-driven byte strobe when the design runs on the board. Clocked from the 12 MHz system clock.

Parameters:
CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200); legal range is 4 or more.
BIT_CNT_W, 8, width of the baud counter; must satisfy 2^BIT_CNT_W > CLKS_PER_BIT.

Ports:
clk12m  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-high reset.
rxd  input  1  asynchronous serial line; idle high; LSB first; 1 start bit, 8 data bits, 1 stop bit.
rx_data  output  8  last correctly framed byte; held until the next good byte.
rx_data_rdy  output  1  one-cycle pulse; rx_data is valid in the same cycle.
rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
rx_busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (asynchronous, active-high): rx_data=8'h00, rx_data_rdy=0, rx_frame_err=0, rx_busy=0. Both synchronizer flops reset to 1. State goes to IDLE and all counters clear.
- Reset mid-frame aborts the partial byte. No strobe is emitted.
- rxd passes through a 2-flop synchronizer before any use; rxs denotes the synchronizer output. Only rxs drives the FSM.
- Cycle numbering: cycle 0 is the posedge at which the first synchronizer flop captures rxd=0.
- IDLE: when rxs==0 (cycle 2), go to START, clear the baud counter, and set rx_busy=1.
- START: count floor(CLKS_PER_BIT/2) cycles, then sample rxs.
  - rxs==0: go to DATA with bit index 0.
  - rxs==1: treat as a glitch and return to IDLE. No strobe; rx_busy drops.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [index], LSB first. After index 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rxs.
  - rxs==1: the next cycle loads rx_data from the shift register, pulses rx_data_rdy for exactly 1 cycle, and returns to IDLE.
  - rxs==0: the next cycle pulses rx_frame_err for 1 cycle, leaves rx_data unchanged, and goes to WAIT_IDLE.
- WAIT_IDLE: remain until rxs==1, then go to IDLE. This prevents a break condition or line-low from being taken as a new start bit.
- rx_busy=0 only in IDLE.
- Latency: rx_data_rdy is asserted at cycle 2 + floor(C/2) + 9*C + 1, where C=CLKS_PER_BIT. For C=4 this is cycle 41.
- Back-to-back frames: IDLE is re-entered one cycle after the stop sample, about C/2 before the stop bit's nominal end. A start edge arriving immediately after the stop bit is therefore caught without loss.
- rx_data_rdy and rx_frame_err are never high in the same cycle. Each fires at most once per frame.
- Baud counter wraps to 0 on each sample. It never exceeds CLKS_PER_BIT-1.
- No FIFO: the consumer must accept every rx_data_rdy pulse. The next good byte overwrites rx_data after at least 10*C cycles.

Test Plan:
(All scenarios use CLKS_PER_BIT=4; bits are driven as 4-cycle windows aligned to the clock.)
1. Release reset, drive frame 0x30 ('0') -> a single rx_data_rdy pulse at cycle 41 with rx_data=8'h30; rx_busy high from cycle 2 to 41; rx_frame_err never asserted.
2. Drive frames '5','2','-' back to back with no idle gap -> three rdy pulses 40 cycles apart carrying 8'h35, 8'h32, 8'h2D; no frame errors.
3. Pull rxd low for 1 cycle, then high -> START aborts; no rdy, no frame error; rx_busy pulses for ≤3 cycles; rx_data unchanged.
4. Receive 0x34 cleanly, then frame 0x41 with stop bit=0, holding rxd low for 12 more cycles before going high -> one rx_frame_err pulse; rx_data stays 8'h34; no rdy; rx_busy stays high until rxs returns high; a following frame 0x2B then yields rdy with rx_data=8'h2B.
5. Assert rst asynchronously (mid-cycle) during data bit 3 of frame 0xA5 -> outputs clear immediately, with no rdy or frame error from that frame; after rst deasserts, frame 0x5A is received correctly at the expected cycle.
6. Frames 0x00 and 0xFF back to back -> rdy pulses carrying 8'h00 then 8'hFF. This confirms the all-zero data frame is not mistaken for a break and that LSB-first ordering is correct.
